// File: rtl/requant_pkg.sv
// requant_pkg: shared widths, int8 bounds and pipeline stage type for acc_requant
package requant_pkg;
  localparam int ACC_W = 32;
  localparam int MULT_W = 16;
  localparam int PROD_W = ACC_W + MULT_W;
  localparam int SHIFT_MAX = 47;
  localparam int QMIN = -128;
  localparam int QMAX = 127;
  typedef struct packed {
    logic v;
    logic sat;
    logic signed [PROD_W:0] d;
  } rq_stage_t;
endpackage

// File: rtl/acc_requant_rq_round_shift.sv
// rq_round_shift: rounding (half toward +inf) arithmetic right shift, shift clamped to SHIFT_MAX
module rq_round_shift import requant_pkg::*; (
  input  logic signed [PROD_W:0] p,
  input  logic        [5:0]      shift,
  output logic signed [PROD_W:0] r
);
  localparam logic signed [PROD_W:0] ONE = 1;
  logic [5:0] sh;
  logic signed [PROD_W:0] bias;
  always_comb begin
    sh = shift > 6'(SHIFT_MAX) ? 6'(SHIFT_MAX) : shift;
    bias = sh == 6'd0 ? '0 : ONE << (sh - 6'd1);
    r = (p + bias) >>> sh;
  end
endmodule

// File: rtl/acc_requant.sv
// acc_requant: 3-stage int32->int8 requantizer (mult, round-shift, zp+clamp); REQUANT_RELU_EN adds cfg_relu
module acc_requant #(
  parameter int ACC_W = 32,
  parameter int MULT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [ACC_W-1:0]  in_acc,
  input  logic                     in_sat,
  input  logic signed [MULT_W-1:0] cfg_mult,
  input  logic        [5:0]        cfg_shift,
  input  logic signed [7:0]        cfg_zp,
`ifdef REQUANT_RELU_EN
  input  logic                     cfg_relu,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [7:0]        out_q,
  output logic                     out_sat,
  input  logic                     clr_stats,
  output logic        [CNT_W-1:0]  sat_cnt,
  output logic                     busy
);
  import requant_pkg::*;
  logic adv, relu, lo_hit, hi_hit;
  rq_stage_t s1, s2;
  (* use_dsp = "yes" *) logic signed [ACC_W+MULT_W-1:0] prod;
  logic signed [PROD_W:0] r, v, zp, lo, hi;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy = s1.v | s2.v | out_valid;
  assign prod = in_acc * cfg_mult;
`ifdef REQUANT_RELU_EN
  assign relu = cfg_relu;
`else
  assign relu = 1'b0;
`endif
  rq_round_shift u_rs (.p(s1.d), .shift(cfg_shift), .r(r));
  always_comb begin
    zp = (PROD_W+1)'(cfg_zp);
    v = $signed(s2.d) + zp;
    lo = relu ? zp : (PROD_W+1)'(QMIN);
    hi = (PROD_W+1)'(QMAX);
    lo_hit = v < lo;
    hi_hit = v > hi;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      out_valid <= 1'b0;
      out_q <= '0;
      out_sat <= 1'b0;
    end else if (adv) begin
      s1 <= '{v: in_valid, sat: in_sat, d: (PROD_W+1)'(prod)};
      s2 <= '{v: s1.v, sat: s1.sat, d: r};
      out_valid <= s2.v;
      out_q <= lo_hit ? lo[7:0] : hi_hit ? hi[7:0] : v[7:0];
      out_sat <= (lo_hit & !relu) | hi_hit | s2.sat;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_cnt <= '0;
    else if (clr_stats) sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
endmodule
